// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl
// Pipeline sequencing controller for the 5-stage MIPS core. Merges the ID
// load-use stall request, multi-cycle EX operations (MULT/DIV) and MEM-stage
// exceptions into a per-stage stall vector, a pipeline flush and a PC
// redirect. Owns the multi-cycle countdown: EX only pulses start and waits
// for done.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal flow; stalls only from load-use or a start pulse
// MC_BUSY | multi-cycle op in flight; counter holds remaining busy cycles
//
// Ports:
//   clk, rst_n        clock, async active-low reset
//   stallreq_id_i     ID load-use hazard (level)
//   ex_mc_start_i     EX begins a multi-cycle op (pulse)
//   ex_mc_op_i        0 = multiply, 1 = divide (valid with start)
//   excp_i            MEM-stage exception this cycle
//   excp_vec_i        handler address (valid with excp_i)
//   stall_o           [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=0
//   flush_o           clear all pipeline registers
//   new_pc_o          redirect PC, zero unless flush_o
//   ex_mc_done_o      multi-cycle result ready (pulse)
//   ex_mc_abort_o     in-flight multi-cycle op cancelled (pulse)
//   busy_o            high while in MC_BUSY
//   stall_cnt_o       saturating count of cycles with stall_o != 0
module pipe_stall_ctrl #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned CNT_W      = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallreq_id_i,
    input  logic        ex_mc_start_i,
    input  logic        ex_mc_op_i,
    input  logic        excp_i,
    input  logic [31:0] excp_vec_i,
    output logic [5:0]  stall_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        ex_mc_done_o,
    output logic        ex_mc_abort_o,
    output logic        busy_o,
    output logic [31:0] stall_cnt_o
);

    typedef enum logic {
        RUN     = 1'b0,
        MC_BUSY = 1'b1
    } state_t;

    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_LU   = 6'b000111;
    localparam logic [5:0] STALL_MC   = 6'b001111;

    // The start cycle itself is the first of N stall cycles, so load N-1.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [31:0]      stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            cnt         <= '0;
            stall_cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Flush cycles never stall, so they drop out of the count here.
            if (stall_o != STALL_NONE && stall_cnt_q != 32'hFFFF_FFFF)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        stall_o       = STALL_NONE;
        flush_o       = 1'b0;
        new_pc_o      = 32'd0;
        ex_mc_done_o  = 1'b0;
        ex_mc_abort_o = 1'b0;

        // Outputs stay quiet while reset is asserted, whatever the inputs do.
        if (rst_n) begin
            if (excp_i) begin
                flush_o  = 1'b1;
                new_pc_o = excp_vec_i;
                if (state == MC_BUSY)
                    ex_mc_abort_o = 1'b1;
                state_nxt = RUN;
                cnt_nxt   = '0;
            end else begin
                unique case (state)
                    RUN: begin
                        if (ex_mc_start_i) begin
                            stall_o   = STALL_MC;
                            cnt_nxt   = ex_mc_op_i ? DIV_LOAD : MUL_LOAD;
                            state_nxt = MC_BUSY;
                        end else if (stallreq_id_i) begin
                            stall_o = STALL_LU;
                        end
                    end
                    MC_BUSY: begin
                        // A load-use request is already covered by the EX stall.
                        if (cnt != '0) begin
                            stall_o = STALL_MC;
                            cnt_nxt = cnt - 1'b1;
                        end else begin
                            ex_mc_done_o = 1'b1;
                            state_nxt    = RUN;
                            stall_o      = stallreq_id_i ? STALL_LU : STALL_NONE;
                        end
                    end
                    default: begin
                        state_nxt = RUN;
                        cnt_nxt   = '0;
                    end
                endcase
            end
        end
    end

    assign busy_o      = rst_n && (state == MC_BUSY);
    assign stall_cnt_o = rst_n ? stall_cnt_q : 32'd0;

    // A start while busy is a protocol error; the FSM ignores it.
    a_no_start_while_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(state == MC_BUSY && ex_mc_start_i && !excp_i));

    a_done_abort_exclusive: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(ex_mc_done_o && ex_mc_abort_o));

endmodule
